// File: rtl/bram_xfer.sv
// ---------------------------------------------------------------------------
// bram_xfer
//
// PL-side transfer engine sitting on BRAM port B. A rising edge on the PS
// GPIO start bit launches either a read (BRAM -> local word buffer) or a
// write (local word buffer -> BRAM at BASE_ADDR + WR_OFFSET). Completion is
// reported as a sticky level (done) plus a one-cycle strobe (done_pulse);
// an out-of-range length produces a one-cycle err_pulse instead. The local
// buffer is exposed to downstream PL logic through a registered read port.
//
// Ports:
//   FCLK_CLK0        in   single clock for the whole block
//   reset            in   synchronous, active-high
//   start_gpio       in   PS GPIO bit, rising edge requests a transfer
//   mode             in   0 = read BRAM into buffer, 1 = write buffer to BRAM
//   len              in   transfer length in words (1..MAX_WORDS)
//   BRAM_PORTB_*     out  BRAM port B clock/reset/enable/we/addr/din
//   BRAM_PORTB_dout  in   BRAM read data, RD_LATENCY cycles after issue
//   buf_raddr        in   buffer read index for downstream logic
//   buf_rdata        out  buffer word, one cycle after buf_raddr
//   busy             out  transfer in progress
//   done             out  last accepted transfer has completed
//   done_pulse       out  one-cycle completion strobe
//   err_pulse        out  one-cycle strobe for a rejected start
// ---------------------------------------------------------------------------
module bram_xfer #(
    parameter int          DATA_W     = 32,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter logic [31:0] WR_OFFSET  = 32'h0000_0400,
    parameter int          MAX_WORDS  = 64,
    parameter int          RD_LATENCY = 1,
    parameter int          LEN_W      = 8,
    localparam int         IDX_W      = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1
) (
    input  logic                  FCLK_CLK0,
    input  logic                  reset,
    input  logic                  start_gpio,
    input  logic                  mode,
    input  logic [LEN_W-1:0]      len,
    output logic                  BRAM_PORTB_clk,
    output logic                  BRAM_PORTB_rst,
    output logic                  BRAM_PORTB_en,
    output logic [DATA_W/8-1:0]   BRAM_PORTB_we,
    output logic [31:0]           BRAM_PORTB_addr,
    output logic [DATA_W-1:0]     BRAM_PORTB_din,
    input  logic [DATA_W-1:0]     BRAM_PORTB_dout,
    input  logic [IDX_W-1:0]      buf_raddr,
    output logic [DATA_W-1:0]     buf_rdata,
    output logic                  busy,
    output logic                  done,
    output logic                  done_pulse,
    output logic                  err_pulse
);

    localparam int               BYTES   = DATA_W / 8;
    localparam logic [31:0]      STEP    = 32'(BYTES);
    localparam logic [31:0]      WR_BASE = BASE_ADDR + WR_OFFSET;
    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_WORDS);
    localparam logic [LEN_W-1:0] ONE     = {{(LEN_W-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_DRAIN,
        ST_WR,
        ST_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [LEN_W-1:0]      i_q, i_d;
    logic [LEN_W-1:0]      len_q, len_d;
    logic [LEN_W-1:0]      cap_cnt_q, cap_cnt_d;
    logic [RD_LATENCY-1:0] vld_q, vld_d;
    logic                  start_d_q, start_d_d;
    logic                  en_q, en_d;
    logic [BYTES-1:0]      we_q, we_d;
    logic [31:0]           addr_q, addr_d;
    logic [DATA_W-1:0]     din_q, din_d;
    logic [DATA_W-1:0]     buf_rdata_q, buf_rdata_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  done_pulse_q, done_pulse_d;
    logic                  err_pulse_q, err_pulse_d;

    logic                  start_evt;
    logic                  capture;
    logic                  buf_we;
    logic [DATA_W-1:0]     buf_mem [MAX_WORDS];

    assign BRAM_PORTB_clk  = FCLK_CLK0;
    assign BRAM_PORTB_rst  = reset;
    assign BRAM_PORTB_en   = en_q;
    assign BRAM_PORTB_we   = we_q;
    assign BRAM_PORTB_addr = addr_q;
    assign BRAM_PORTB_din  = din_q;
    assign buf_rdata       = buf_rdata_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign done_pulse      = done_pulse_q;
    assign err_pulse       = err_pulse_q;

    // The oldest stage of the valid pipeline marks the cycle in which
    // BRAM_PORTB_dout holds a word we asked for; captures land in issue order.
    assign start_evt = start_gpio & ~start_d_q;
    assign capture   = vld_q[RD_LATENCY-1];
    assign buf_we    = capture & ~reset;

    // Next-state logic. All BRAM port signals are derived from the next
    // state and index so that they come straight out of flops.
    always_comb begin
        state_d      = state_q;
        i_d          = i_q;
        len_d        = len_q;
        cap_cnt_d    = cap_cnt_q + {{(LEN_W-1){1'b0}}, capture};
        start_d_d    = start_gpio;
        done_d       = done_q;
        err_pulse_d  = 1'b0;
        vld_d        = '0;
        en_d         = 1'b0;
        we_d         = '0;
        addr_d       = '0;
        din_d        = '0;

        // A read is in flight for every cycle the port was enabled without
        // write enables; the shift register ages it until its data returns.
        vld_d[0] = en_q & (we_q == '0);
        for (int k = 1; k < RD_LATENCY; k++) begin
            vld_d[k] = vld_q[k-1];
        end

        case (state_q)
            ST_IDLE: begin
                if (start_evt) begin
                    if (len == '0 || len > MAX_LEN) begin
                        err_pulse_d = 1'b1;
                    end else begin
                        done_d    = 1'b0;
                        len_d     = len;
                        i_d       = '0;
                        cap_cnt_d = '0;
                        state_d   = mode ? ST_WR : ST_RD;
                    end
                end
            end
            ST_RD: begin
                if (i_q == len_q - ONE) begin
                    state_d = ST_DRAIN;
                end else begin
                    i_d = i_q + ONE;
                end
            end
            ST_DRAIN: begin
                // Leave on the same edge that stores the final word.
                if (cap_cnt_d == len_q) begin
                    state_d = ST_DONE;
                end
            end
            ST_WR: begin
                if (i_q == len_q - ONE) begin
                    state_d = ST_DONE;
                end else begin
                    i_d = i_q + ONE;
                end
            end
            ST_DONE: begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (state_d == ST_RD) begin
            en_d   = 1'b1;
            addr_d = BASE_ADDR + 32'(i_d) * STEP;
        end else if (state_d == ST_WR) begin
            en_d   = 1'b1;
            we_d   = '1;
            addr_d = WR_BASE + 32'(i_d) * STEP;
            din_d  = buf_mem[i_d[IDX_W-1:0]];
        end

        busy_d       = (state_d != ST_IDLE);
        done_pulse_d = (state_d == ST_DONE);
        buf_rdata_d  = buf_mem[buf_raddr];
    end

    // Control and output registers; reset drops any in-flight reads.
    always_ff @(posedge FCLK_CLK0) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            i_q          <= '0;
            len_q        <= '0;
            cap_cnt_q    <= '0;
            vld_q        <= '0;
            start_d_q    <= 1'b0;
            en_q         <= 1'b0;
            we_q         <= '0;
            addr_q       <= '0;
            din_q        <= '0;
            buf_rdata_q  <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            done_pulse_q <= 1'b0;
            err_pulse_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            i_q          <= i_d;
            len_q        <= len_d;
            cap_cnt_q    <= cap_cnt_d;
            vld_q        <= vld_d;
            start_d_q    <= start_d_d;
            en_q         <= en_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            din_q        <= din_d;
            buf_rdata_q  <= buf_rdata_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            done_pulse_q <= done_pulse_d;
            err_pulse_q  <= err_pulse_d;
        end
    end

    // Word buffer storage: deliberately never cleared so its contents
    // survive both reset and subsequent transfers.
    always_ff @(posedge FCLK_CLK0) begin
        if (buf_we) begin
            buf_mem[cap_cnt_q[IDX_W-1:0]] <= BRAM_PORTB_dout;
        end
    end

endmodule

// File: tb/tb_bram_xfer.sv
// ---------------------------------------------------------------------------
// tb_bram_xfer
//
// Directed bench for bram_xfer. Two instances share the stimulus: dut A uses
// a one-cycle BRAM and dut B a two-cycle BRAM, each with its own behavioural
// BRAM model. Read data for word index w (< 256) is rd_base + w; the upper
// half of each model is ordinary writable storage.
// ---------------------------------------------------------------------------
module tb_bram_xfer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_gpio;
    logic        mode;
    logic [7:0]  len;
    logic [5:0]  buf_raddr;
    logic [31:0] rd_base;

    logic        a_bram_clk, a_bram_rst, a_en, a_busy, a_done, a_done_pulse, a_err_pulse;
    logic [3:0]  a_we;
    logic [31:0] a_addr, a_din, a_dout, a_buf_rdata;
    logic        b_bram_clk, b_bram_rst, b_en, b_busy, b_done, b_done_pulse, b_err_pulse;
    logic [3:0]  b_we;
    logic [31:0] b_addr, b_din, b_dout, b_buf_rdata;

    logic [31:0] wmem_a [0:511];
    logic [31:0] wmem_b [0:511];
    logic [31:0] a_rd1, b_rd1, b_rd2;

    int checks = 0;
    int errors = 0;

    int          en_cnt_a, en_cnt_b, dp_cnt_a, dp_cnt_b, err_cnt_a, err_cnt_b;
    int          dp_off_a, dp_off_b, err_off_a, busy_low_a;
    logic [31:0] max_addr_b;
    logic [31:0] addr_log_a [0:63];
    logic [3:0]  we_log_a [0:63];

    always #5 clk = ~clk;

    bram_xfer #(.RD_LATENCY(1)) dut_a (
        .FCLK_CLK0(clk), .reset(reset), .start_gpio(start_gpio), .mode(mode), .len(len),
        .BRAM_PORTB_clk(a_bram_clk), .BRAM_PORTB_rst(a_bram_rst), .BRAM_PORTB_en(a_en),
        .BRAM_PORTB_we(a_we), .BRAM_PORTB_addr(a_addr), .BRAM_PORTB_din(a_din),
        .BRAM_PORTB_dout(a_dout), .buf_raddr(buf_raddr), .buf_rdata(a_buf_rdata),
        .busy(a_busy), .done(a_done), .done_pulse(a_done_pulse), .err_pulse(a_err_pulse)
    );

    bram_xfer #(.RD_LATENCY(2)) dut_b (
        .FCLK_CLK0(clk), .reset(reset), .start_gpio(start_gpio), .mode(mode), .len(len),
        .BRAM_PORTB_clk(b_bram_clk), .BRAM_PORTB_rst(b_bram_rst), .BRAM_PORTB_en(b_en),
        .BRAM_PORTB_we(b_we), .BRAM_PORTB_addr(b_addr), .BRAM_PORTB_din(b_din),
        .BRAM_PORTB_dout(b_dout), .buf_raddr(buf_raddr), .buf_rdata(b_buf_rdata),
        .busy(b_busy), .done(b_done), .done_pulse(b_done_pulse), .err_pulse(b_err_pulse)
    );

    // One-cycle BRAM model for dut A.
    always @(posedge clk) begin
        if (a_en) begin
            if (a_we != 4'h0) wmem_a[a_addr[10:2]] <= a_din;
            else a_rd1 <= (a_addr[10:2] < 9'd256) ? rd_base + 32'(a_addr[10:2]) : wmem_a[a_addr[10:2]];
        end
    end
    assign a_dout = a_rd1;

    // Two-cycle BRAM model for dut B (array read plus output register).
    always @(posedge clk) begin
        if (b_en) begin
            if (b_we != 4'h0) wmem_b[b_addr[10:2]] <= b_din;
            else b_rd1 <= (b_addr[10:2] < 9'd256) ? rd_base + 32'(b_addr[10:2]) : wmem_b[b_addr[10:2]];
        end
        b_rd2 <= b_rd1;
    end
    assign b_dout = b_rd2;

    // Global guard against a hung run.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Raise start at a negedge so the next posedge is E0; drop it 1 ns later.
    task automatic applyStimulus(input logic m, input logic [7:0] l);
        @(negedge clk);
        mode       = m;
        len        = l;
        start_gpio = 1'b1;
        @(posedge clk);
        #1 start_gpio = 1'b0;
    endtask

    // Sample both DUTs once per cycle after E0 (offset k = cycle after Ek)
    // until both are idle. Optionally re-raise start mid-transfer.
    task automatic watch(input int budget, input int restartAt);
        en_cnt_a = 0; en_cnt_b = 0; dp_cnt_a = 0; dp_cnt_b = 0;
        err_cnt_a = 0; err_cnt_b = 0; dp_off_a = -1; dp_off_b = -1;
        err_off_a = -1; busy_low_a = -1; max_addr_b = 32'h0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (a_en) begin
                if (en_cnt_a < 64) begin
                    addr_log_a[en_cnt_a] = a_addr;
                    we_log_a[en_cnt_a]   = a_we;
                end
                en_cnt_a++;
            end
            if (b_en) begin
                en_cnt_b++;
                if (b_addr > max_addr_b) max_addr_b = b_addr;
            end
            if (a_done_pulse) begin dp_cnt_a++; dp_off_a = k; end
            if (b_done_pulse) begin dp_cnt_b++; dp_off_b = k; end
            if (a_err_pulse) begin err_cnt_a++; err_off_a = k; end
            if (b_err_pulse) err_cnt_b++;
            if (!a_busy && busy_low_a < 0) busy_low_a = k;
            if (k == restartAt) begin
                len = 8'd20; mode = 1'b1; start_gpio = 1'b1;
            end
            if (k == restartAt + 1) start_gpio = 1'b0;
            if (k >= 1 && !a_busy && !b_busy) break;
        end
        checkOutput("idle_a", {31'b0, a_busy}, 32'h0);
        checkOutput("idle_b", {31'b0, b_busy}, 32'h0);
    endtask

    task automatic readBuf(input int idx, output logic [31:0] va, output logic [31:0] vb);
        @(negedge clk);
        buf_raddr = 6'(idx);
        @(negedge clk);
        va = a_buf_rdata;
        vb = b_buf_rdata;
    endtask

    logic [31:0] va, vb;

    initial begin
        reset = 1'b1; start_gpio = 1'b0; mode = 1'b0; len = 8'd0;
        buf_raddr = 6'd0; rd_base = 32'hA500_0000;
        repeat (3) @(posedge clk);
        @(negedge clk);

        // Reset values.
        checkOutput("rst_en",         {31'b0, a_en}, 32'h0);
        checkOutput("rst_we",         {28'b0, a_we}, 32'h0);
        checkOutput("rst_addr",       a_addr, 32'h0);
        checkOutput("rst_din",        a_din, 32'h0);
        checkOutput("rst_buf_rdata",  a_buf_rdata, 32'h0);
        checkOutput("rst_busy",       {31'b0, a_busy}, 32'h0);
        checkOutput("rst_done",       {31'b0, a_done}, 32'h0);
        checkOutput("rst_done_pulse", {31'b0, a_done_pulse}, 32'h0);
        checkOutput("rst_err_pulse",  {31'b0, a_err_pulse}, 32'h0);
        checkOutput("rst_b_en",       {31'b0, b_en}, 32'h0);
        checkOutput("rst_bram_rst_a", {31'b0, a_bram_rst}, {31'b0, reset});
        checkOutput("rst_bram_rst_b", {31'b0, b_bram_rst}, {31'b0, reset});
        checkOutput("bram_clk_a",     {31'b0, a_bram_clk}, {31'b0, clk});
        checkOutput("bram_clk_b",     {31'b0, b_bram_clk}, {31'b0, clk});
        reset = 1'b0;

        // Read of 10 words.
        $display("[TB] read N=10");
        applyStimulus(1'b0, 8'd10);
        watch(200, -1);
        checkOutput("rd10_en_cnt_a", 32'(en_cnt_a), 32'd10);
        checkOutput("rd10_en_cnt_b", 32'(en_cnt_b), 32'd10);
        for (int k = 0; k < 10; k++) checkOutput("rd10_addr_a", addr_log_a[k], 32'(4 * k));
        checkOutput("rd10_dp_off_a", 32'(dp_off_a), 32'd11);
        checkOutput("rd10_dp_cnt_a", 32'(dp_cnt_a), 32'd1);
        checkOutput("rd10_dp_off_b", 32'(dp_off_b), 32'd12);
        checkOutput("rd10_busy_low_a", 32'(busy_low_a), 32'd12);
        checkOutput("rd10_done_a", {31'b0, a_done}, 32'h1);
        for (int k = 0; k < 10; k++) begin
            readBuf(k, va, vb);
            checkOutput("rd10_buf_a", va, 32'hA500_0000 + 32'(k));
            checkOutput("rd10_buf_b", vb, 32'hA500_0000 + 32'(k));
        end

        // Read of MAX_WORDS words.
        $display("[TB] read N=64");
        applyStimulus(1'b0, 8'd64);
        watch(300, -1);
        checkOutput("rd64_en_cnt_b", 32'(en_cnt_b), 32'd64);
        checkOutput("rd64_max_addr_b", max_addr_b, 32'h0000_00FC);
        checkOutput("rd64_dp_off_b", 32'(dp_off_b), 32'd66);
        checkOutput("rd64_dp_off_a", 32'(dp_off_a), 32'd65);
        for (int k = 0; k < 64; k++) begin
            readBuf(k, va, vb);
            checkOutput("rd64_buf_b", vb, 32'hA500_0000 + 32'(k));
        end

        // Write of 5 words back to offset 0x400.
        $display("[TB] write N=5");
        applyStimulus(1'b1, 8'd5);
        watch(200, -1);
        checkOutput("wr5_en_cnt_a", 32'(en_cnt_a), 32'd5);
        for (int k = 0; k < 5; k++) begin
            checkOutput("wr5_addr_a", addr_log_a[k], 32'h400 + 32'(4 * k));
            checkOutput("wr5_we_a", {28'b0, we_log_a[k]}, 32'hF);
            checkOutput("wr5_mem_a", wmem_a[256 + k], 32'hA500_0000 + 32'(k));
            checkOutput("wr5_mem_b", wmem_b[256 + k], 32'hA500_0000 + 32'(k));
        end
        checkOutput("wr5_dp_off_a", 32'(dp_off_a), 32'd5);
        checkOutput("wr5_busy_low_a", 32'(busy_low_a), 32'd6);

        // Rejected starts.
        $display("[TB] rejected lengths");
        applyStimulus(1'b0, 8'd0);
        watch(10, -1);
        checkOutput("len0_err_cnt_a", 32'(err_cnt_a), 32'd1);
        checkOutput("len0_err_off_a", 32'(err_off_a), 32'd0);
        checkOutput("len0_err_cnt_b", 32'(err_cnt_b), 32'd1);
        checkOutput("len0_en_cnt_a", 32'(en_cnt_a), 32'd0);
        checkOutput("len0_dp_cnt_a", 32'(dp_cnt_a), 32'd0);
        checkOutput("len0_done_a", {31'b0, a_done}, 32'h1);
        applyStimulus(1'b1, 8'd65);
        watch(10, -1);
        checkOutput("len65_err_cnt_a", 32'(err_cnt_a), 32'd1);
        checkOutput("len65_en_cnt_a", 32'(en_cnt_a), 32'd0);
        checkOutput("len65_en_cnt_b", 32'(en_cnt_b), 32'd0);
        checkOutput("len65_done_a", {31'b0, a_done}, 32'h1);

        // Second rising edge while busy is ignored.
        $display("[TB] restart while busy");
        applyStimulus(1'b0, 8'd3);
        watch(100, 1);
        checkOutput("busy_en_cnt_a", 32'(en_cnt_a), 32'd3);
        checkOutput("busy_err_cnt_a", 32'(err_cnt_a), 32'd0);
        checkOutput("busy_err_cnt_b", 32'(err_cnt_b), 32'd0);
        checkOutput("busy_dp_off_a", 32'(dp_off_a), 32'd4);
        checkOutput("busy_we_a", {28'b0, we_log_a[2]}, 32'h0);
        repeat (3) @(negedge clk);
        checkOutput("busy_no_rerun_a", {31'b0, a_busy}, 32'h0);

        // Reset on E4 of a 10-word read, then a full read of new data.
        $display("[TB] reset mid-transfer");
        rd_base = 32'h5A00_0000;
        applyStimulus(1'b0, 8'd10);
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("midrst_en_a", {31'b0, a_en}, 32'h0);
        checkOutput("midrst_busy_a", {31'b0, a_busy}, 32'h0);
        checkOutput("midrst_done_a", {31'b0, a_done}, 32'h0);
        checkOutput("midrst_busy_b", {31'b0, b_busy}, 32'h0);
        reset = 1'b0;
        applyStimulus(1'b0, 8'd10);
        watch(200, -1);
        checkOutput("post_en_cnt_a", 32'(en_cnt_a), 32'd10);
        checkOutput("post_dp_off_a", 32'(dp_off_a), 32'd11);
        checkOutput("post_done_a", {31'b0, a_done}, 32'h1);
        for (int k = 0; k < 10; k++) begin
            readBuf(k, va, vb);
            checkOutput("post_buf_a", va, 32'h5A00_0000 + 32'(k));
            checkOutput("post_buf_b", vb, 32'h5A00_0000 + 32'(k));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
